// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with configurable data width, parity and stop length.
// Frame results are registered at the stop-bit sample and held until the next accepted frame.
module uart_rx_cfg #(
    parameter int DBIT       = 8,
    parameter int OVS        = 16,
    parameter int SB_TICK    = 16,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       s_tick,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       parity_err,
    output logic       frame_err
);
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    localparam logic [4:0] S_MID  = 5'(OVS / 2 - 1);
    localparam logic [4:0] S_BIT  = 5'(OVS - 1);
    localparam logic [4:0] S_STOP = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST = 3'(DBIT - 1);
    localparam int         SHIFT  = 8 - DBIT;

    logic       r_sync1;
    logic       r_sync2;
    state_t     r_state;
    logic [4:0] r_s;
    logic [2:0] r_n;
    logic [7:0] r_shift;
    logic       r_par;
    logic       r_armed;
    logic       w_rx_s;
    logic [7:0] w_data;
    logic       w_pe;

    assign w_rx_s = r_sync2;
    assign w_data = r_shift >> SHIFT;
    assign w_pe   = PARITY_EN ? ((^w_data) ^ r_par ^ PARITY_ODD) : 1'b0;

    // NOTE: the synchronizer resets to the idle-line level so leaving reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // NOTE: every register in this clocked block uses <= so all reads see the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_s          <= '0;
            r_n          <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_armed      <= 1'b1;
            rx_done_tick <= 1'b0;
            dout         <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rx_s) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state <= ST_START;
                        r_s     <= '0;
                    end
                end
                ST_START: if (s_tick) begin
                    if (r_s == S_MID) begin
                        if (w_rx_s) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_DATA;
                            r_s     <= '0;
                            r_n     <= '0;
                        end
                    end else begin
                        r_s <= r_s + 5'd1;
                    end
                end
                ST_DATA: if (s_tick) begin
                    if (r_s == S_BIT) begin
                        r_s     <= '0;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        if (r_n == N_LAST) begin
                            r_state <= PARITY_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            r_n <= r_n + 3'd1;
                        end
                    end else begin
                        r_s <= r_s + 5'd1;
                    end
                end
                ST_PARITY: if (s_tick) begin
                    if (r_s == S_BIT) begin
                        r_par   <= w_rx_s;
                        r_state <= ST_STOP;
                        r_s     <= '0;
                    end else begin
                        r_s <= r_s + 5'd1;
                    end
                end
                ST_STOP: if (s_tick) begin
                    if (r_s == S_STOP) begin
                        r_state      <= ST_IDLE;
                        rx_done_tick <= 1'b1;
                        dout         <= w_data;
                        parity_err   <= w_pe;
                        frame_err    <= ~w_rx_s;
                        // A low stop bit may be a break; wait for the line to return high first.
                        if (!w_rx_s) r_armed <= 1'b0;
                    end else begin
                        r_s <= r_s + 5'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four parameter variants, a frame-level reference model and a per-cycle compare.
// Directed scenarios pin the model with literal values; a randomized loop then covers the rest.
module tb_uart_rx_cfg;
    localparam int NDUT = 4;

    typedef struct {
        int         k;
        logic [7:0] dout;
        logic       pe;
        logic       fe;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            s_tick = 1'b0;
    logic [NDUT-1:0] rx_l = '1;
    wire  [NDUT-1:0] done_w;
    wire  [NDUT-1:0] pe_w;
    wire  [NDUT-1:0] fe_w;
    wire  [7:0]      dout_w [NDUT];

    exp_t       exp_q[$];
    logic [7:0] m_dout [NDUT];
    logic       m_pe [NDUT];
    logic       m_fe [NDUT];
    int         done_cnt [NDUT];
    int         n_checks = 0;
    int         n_pass = 0;
    int         tick_div = 1;

    uart_rx_cfg u0 (.clk(clk), .rst_n(rst_n), .rx(rx_l[0]), .s_tick(s_tick),
        .rx_done_tick(done_w[0]), .dout(dout_w[0]), .parity_err(pe_w[0]), .frame_err(fe_w[0]));
    uart_rx_cfg #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (.clk(clk), .rst_n(rst_n), .rx(rx_l[1]),
        .s_tick(s_tick), .rx_done_tick(done_w[1]), .dout(dout_w[1]), .parity_err(pe_w[1]),
        .frame_err(fe_w[1]));
    uart_rx_cfg #(.DBIT(7)) u2 (.clk(clk), .rst_n(rst_n), .rx(rx_l[2]), .s_tick(s_tick),
        .rx_done_tick(done_w[2]), .dout(dout_w[2]), .parity_err(pe_w[2]), .frame_err(fe_w[2]));
    uart_rx_cfg #(.DBIT(5), .OVS(8), .SB_TICK(12), .PARITY_EN(1), .PARITY_ODD(1)) u3 (.clk(clk),
        .rst_n(rst_n), .rx(rx_l[3]), .s_tick(s_tick), .rx_done_tick(done_w[3]), .dout(dout_w[3]),
        .parity_err(pe_w[3]), .frame_err(fe_w[3]));

    function automatic int dbit_of(input int k);
        case (k)
            2:       return 7;
            3:       return 5;
            default: return 8;
        endcase
    endfunction
    function automatic int ovs_of(input int k);   return (k == 3) ? 8 : 16;  endfunction
    function automatic int sb_of(input int k);    return (k == 3) ? 12 : 16; endfunction
    function automatic bit pen_of(input int k);   return (k == 1) || (k == 3); endfunction
    function automatic bit odd_of(input int k);   return (k == 3);           endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic drive(input int k, input logic v, input int n);
        rx_l[k] = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int k, input int n);
        drive(k, 1'b1, n);
    endtask

    // Serialises one frame on line k; when expect_it is set the frame's result is queued for the compare.
    task automatic send_frame(input int k, input logic [7:0] data, input logic p, input logic stop,
                              input bit expect_it);
        int         bclk;
        logic [7:0] mask;
        exp_t       e;
        bclk = ovs_of(k) * tick_div;
        mask = 8'((1 << dbit_of(k)) - 1);
        if (expect_it) begin
            e.k    = k;
            e.dout = data & mask;
            e.pe   = pen_of(k) ? ((^(data & mask)) ^ p ^ odd_of(k)) : 1'b0;
            e.fe   = ~stop;
            exp_q.push_back(e);
        end
        drive(k, 1'b0, bclk);
        for (int i = 0; i < dbit_of(k); i++) drive(k, data[i], bclk);
        if (pen_of(k)) drive(k, p, bclk);
        drive(k, stop, sb_of(k) * tick_div);
    endtask

    initial forever #5 clk = ~clk;

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            cnt    = (cnt + 1) % tick_div;
            s_tick = (cnt == 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal;
    end

    // Per-cycle compare: outputs must equal the last accepted frame's result, or zero after reset.
    initial begin
        for (int k = 0; k < NDUT; k++) begin
            m_dout[k] = '0; m_pe[k] = 1'b0; m_fe[k] = 1'b0; done_cnt[k] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                exp_q.delete();
                for (int k = 0; k < NDUT; k++) begin
                    m_dout[k] = '0; m_pe[k] = 1'b0; m_fe[k] = 1'b0;
                end
                check("done low in reset", 32'(done_w), 32'd0);
            end else begin
                for (int k = 0; k < NDUT; k++) begin
                    if (done_w[k]) begin
                        logic ok;
                        done_cnt[k]++;
                        ok = (exp_q.size() != 0) && (exp_q[0].k == k);
                        check($sformatf("dut%0d done expected", k), 32'(ok), 32'd1);
                        if (ok) begin
                            exp_t e;
                            e = exp_q.pop_front();
                            m_dout[k] = e.dout; m_pe[k] = e.pe; m_fe[k] = e.fe;
                        end
                    end
                end
            end
            for (int k = 0; k < NDUT; k++)
                check($sformatf("dut%0d {fe,pe,dout}", k), {22'd0, fe_w[k], pe_w[k], dout_w[k]},
                      {22'd0, m_fe[k], m_pe[k], m_dout[k]});
        end
    end

    initial begin
        int d0;
        int k;
        repeat (5) @(negedge clk);
        check("reset dout0", 32'(dout_w[0]), 32'd0);
        rst_n = 1'b1;
        idle(0, 10);

        d0 = done_cnt[0];
        send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
        idle(0, 20);
        check("A5 dout", 32'(dout_w[0]), 32'hA5);
        check("A5 flags", {30'd0, fe_w[0], pe_w[0]}, 32'd0);
        check("A5 one done", done_cnt[0] - d0, 32'd1);

        d0 = done_cnt[0];
        drive(0, 1'b0, 4);
        idle(0, 40);
        check("glitch no done", done_cnt[0] - d0, 32'd0);
        check("glitch dout held", 32'(dout_w[0]), 32'hA5);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1);
        idle(0, 20);
        check("after glitch dout", 32'(dout_w[0]), 32'h5A);

        send_frame(1, 8'h07, 1'b0, 1'b1, 1'b1);
        idle(1, 20);
        check("par p0 pe", 32'(pe_w[1]), 32'd1);
        check("par p0 dout", 32'(dout_w[1]), 32'h07);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        idle(1, 20);
        check("par p1 pe", 32'(pe_w[1]), 32'd0);
        check("par p1 dout", 32'(dout_w[1]), 32'h07);

        d0 = done_cnt[0];
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        check("break fe", 32'(fe_w[0]), 32'd1);
        check("break dout", 32'(dout_w[0]), 32'h55);
        drive(0, 1'b0, 40);
        idle(0, 32);
        check("break no extra done", done_cnt[0] - d0, 32'd1);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
        idle(0, 20);
        check("post-break dout", 32'(dout_w[0]), 32'h3C);
        check("post-break fe", 32'(fe_w[0]), 32'd0);

        send_frame(2, 8'h41, 1'b0, 1'b1, 1'b1);
        idle(2, 20);
        check("dbit7 dout", 32'(dout_w[2]), 32'h41);
        check("dbit7 msb", 32'(dout_w[2][7]), 32'd0);
        tick_div = 3;
        idle(2, 10);
        send_frame(2, 8'h33, 1'b0, 1'b1, 1'b1);
        idle(2, 60);
        send_frame(2, 8'h41, 1'b0, 1'b1, 1'b1);
        idle(2, 60);
        check("dbit7 tick3 dout", 32'(dout_w[2]), 32'h41);
        tick_div = 1;
        idle(2, 10);

        d0 = done_cnt[0];
        drive(0, 1'b0, 16);
        drive(0, 1'b1, 16);
        drive(0, 1'b0, 16);
        drive(0, 1'b1, 16);
        drive(0, 1'b1, 8);
        rst_n   = 1'b0;
        rx_l[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("rst dout0", 32'(dout_w[0]), 32'd0);
        check("rst dout1", 32'(dout_w[1]), 32'd0);
        check("rst dout2", 32'(dout_w[2]), 32'd0);
        check("rst flags", {24'd0, pe_w, fe_w}, 32'd0);
        rst_n = 1'b1;
        idle(0, 40);
        check("rst no done", done_cnt[0] - d0, 32'd0);
        send_frame(0, 8'h12, 1'b0, 1'b1, 1'b1);
        idle(0, 20);
        check("post-rst dout", 32'(dout_w[0]), 32'h12);

        for (int it = 0; it < 40; it++) begin
            logic stop;
            k        = $urandom_range(NDUT - 1);
            tick_div = $urandom_range(3, 1);
            idle(k, 4);
            if ($urandom_range(4) == 0) begin
                drive(k, 1'b0, $urandom_range(ovs_of(k) / 2 - 2, 1));
                idle(k, 2 * ovs_of(k) * tick_div + 4);
            end
            stop = ($urandom_range(5) != 0);
            send_frame(k, 8'($urandom), 1'($urandom), stop, 1'b1);
            idle(k, $urandom_range(20, 4));
        end
        tick_div = 1;
        idle(0, 50);
        check("all frames delivered", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
